// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Moore FSM: every datapath control line is decoded from the current state and the IR opcode.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instruction,
  input  logic       zeroFlag,
  output logic       writeEnableAC,
  output logic       writeEnableR,
  output logic       writeEnableMem,
  output logic       PCEnable,
  output logic       instructionRegisterEnable,
  output logic       MSBaddressEnable,
  output logic       LSBaddressEnable,
  output logic       zeroEnable,
  output logic       muxSelectPC,
  output logic       muxSelectZero,
  output logic       muxSelectAddress,
  output logic       muxSelectALUtoAC,
  output logic       muxSelectMEM_or_R_toAC,
  output logic [2:0] ALUselectLine,
  output logic       instrDone
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_ADDR_LO = 3'd2,
    S_ADDR_HI = 3'd3,
    S_EXEC    = 3'd4
  } state_t;

  state_t state_reg, state_next;

  logic [3:0] op;
  logic       legal;
  logic       is_nop;
  logic       is_addr_op;

  assign op         = instruction[3:0];
  assign legal      = (instruction[7:4] == 4'h0);
  assign is_nop     = !legal || (op == 4'h0);
  assign is_addr_op = legal && ((op == 4'h1) || (op == 4'h2) || (op == 4'h5) ||
                                (op == 4'h6) || (op == 4'h7));

  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= S_FETCH;
    else
      state_reg <= state_next;
  end

  // Outputs are forced low while reset is high so no write can land on the reset edge.
  always_comb begin
    state_next                = S_FETCH;
    writeEnableAC             = 1'b0;
    writeEnableR              = 1'b0;
    writeEnableMem            = 1'b0;
    PCEnable                  = 1'b0;
    instructionRegisterEnable = 1'b0;
    MSBaddressEnable          = 1'b0;
    LSBaddressEnable          = 1'b0;
    zeroEnable                = 1'b0;
    muxSelectPC               = 1'b0;
    muxSelectZero             = 1'b0;
    muxSelectAddress          = 1'b0;
    muxSelectALUtoAC          = 1'b0;
    muxSelectMEM_or_R_toAC    = 1'b0;
    ALUselectLine             = 3'b000;
    instrDone                 = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          instructionRegisterEnable = 1'b1;
          PCEnable                  = 1'b1;
          state_next                = S_DECODE;
        end
        S_DECODE: begin
          if (is_nop) begin
            instrDone  = 1'b1;
            state_next = S_FETCH;
          end else if (is_addr_op) begin
            state_next = S_ADDR_LO;
          end else begin
            state_next = S_EXEC;
          end
        end
        S_ADDR_LO: begin
          LSBaddressEnable = 1'b1;
          PCEnable         = 1'b1;
          state_next       = S_ADDR_HI;
        end
        S_ADDR_HI: begin
          MSBaddressEnable = 1'b1;
          PCEnable         = 1'b1;
          state_next       = S_EXEC;
        end
        S_EXEC: begin
          instrDone  = 1'b1;
          state_next = S_FETCH;
          if (legal) begin
            case (op)
              4'h1: begin
                muxSelectAddress = 1'b1;
                muxSelectALUtoAC = 1'b1;
                writeEnableAC    = 1'b1;
              end
              4'h2: begin
                muxSelectAddress = 1'b1;
                writeEnableMem   = 1'b1;
              end
              4'h3: writeEnableR = 1'b1;
              4'h4: begin
                muxSelectALUtoAC       = 1'b1;
                muxSelectMEM_or_R_toAC = 1'b1;
                writeEnableAC          = 1'b1;
              end
              4'h5: begin
                muxSelectPC = 1'b1;
                PCEnable    = 1'b1;
              end
              4'h6: begin
                muxSelectPC = 1'b1;
                PCEnable    = zeroFlag;
              end
              4'h7: begin
                muxSelectPC = 1'b1;
                PCEnable    = ~zeroFlag;
              end
              default: begin
                if (op[3]) begin
                  writeEnableAC = 1'b1;
                  zeroEnable    = 1'b1;
                  ALUselectLine = op[2:0];
                  muxSelectZero = (op[2:0] == 3'b011);
                end
              end
            endcase
          end
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
- Sits directly upstream of the datapath and drives every enable, mux select and ALU select line the datapath consumes.
- Reads back the instruction register contents and the Z flag.
- Moore-style FSM: outputs are decoded from current state plus IR opcode; no datapath logic lives here.

Parameters:
none

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
instruction  in  8  current instruction register contents (opcode)
zeroFlag  in  1  Z register output from datapath
writeEnableAC  out  1  load AC
writeEnableR  out  1  load R from AC
writeEnableMem  out  1  memory write of AC at the selected address
PCEnable  out  1  load PC
instructionRegisterEnable  out  1  load IR from memory read data
MSBaddressEnable  out  1  load address-high register from memory read data
LSBaddressEnable  out  1  load address-low register from memory read data
zeroEnable  out  1  load Z register
muxSelectPC  out  1  0 = PC+1, 1 = {MSB,LSB} jump target
muxSelectZero  out  1  0 = (ALU result == 0), 1 = constant 1
muxSelectAddress  out  1  0 = PC drives memory address, 1 = {MSB,LSB}
muxSelectALUtoAC  out  1  0 = ALU result to AC, 1 = MEM/R mux to AC
muxSelectMEM_or_R_toAC  out  1  0 = memory read data, 1 = R
ALUselectLine  out  3  000 ADD, 001 SUB, 010 INC, 011 CLR, 100 AND, 101 OR, 110 XOR, 111 NOT
instrDone  out  1  one-cycle pulse in the last cycle of every instruction (verification hook)

Behaviour:
- Reset: synchronous. While reset=1, all outputs are 0. On the first edge after reset=0, the FSM state is FETCH. The datapath clears PC to 0000h.
- Opcodes (instruction[7:4] must be 0000):
  - 00 NOP, 01 LDAC, 02 STAC, 03 MVAC (R<-AC), 04 MOVR (AC<-R), 05 JUMP, 06 JMPZ, 07 JPNZ
  - 08 ADD, 09 SUB, 0A INAC, 0B CLAC, 0C AND, 0D OR, 0E XOR, 0F NOT
- Any other opcode executes as NOP. instrDone is asserted in DECODE for it.
- Address operands are the two bytes after the opcode, low byte first.
- Memory read is combinational. Writes and register loads take effect on the rising edge.
- FETCH: muxSelectAddress=0, instructionRegisterEnable=1, PCEnable=1, muxSelectPC=0. Next state is DECODE.
- DECODE: no enables. Transitions:
  - NOP/illegal -> FETCH (instrDone=1)
  - LDAC, STAC, JUMP, JMPZ, JPNZ -> ADDR_LO
  - all others -> EXEC
- ADDR_LO: muxSelectAddress=0, LSBaddressEnable=1, PCEnable=1, muxSelectPC=0. Next state is ADDR_HI.
- ADDR_HI: same as ADDR_LO but with MSBaddressEnable=1. Next state is EXEC.
- EXEC (instrDone=1, next state FETCH):
  - LDAC: muxSelectAddress=1, muxSelectALUtoAC=1, muxSelectMEM_or_R_toAC=0, writeEnableAC=1.
  - STAC: muxSelectAddress=1, writeEnableMem=1.
  - MVAC: writeEnableR=1.
  - MOVR: muxSelectALUtoAC=1, muxSelectMEM_or_R_toAC=1, writeEnableAC=1.
  - JUMP: muxSelectPC=1, PCEnable=1.
  - JMPZ: PCEnable=zeroFlag, muxSelectPC=1. JPNZ: PCEnable=~zeroFlag, muxSelectPC=1. zeroFlag is sampled combinationally in EXEC.
  - ALU ops 08–0F: muxSelectALUtoAC=0, writeEnableAC=1, zeroEnable=1, ALUselectLine = opcode[2:0] mapped per the Ports list. For CLAC only, muxSelectZero=1.
  - LDAC, MOVR, MVAC, STAC and jumps never assert zeroEnable. Z is unchanged by them.
- Latency: NOP 2 cycles; register/ALU ops 3 cycles; address ops 5 cycles (not-taken JMPZ/JPNZ included).
- Any unlisted output in a state is 0. The ALUselectLine default is 000.
- Reset asserted in any state aborts the instruction. No partial write completes on or after the reset edge.
- The unused state encodings recover to FETCH.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0 during reset. The first post-reset cycle is FETCH with instructionRegisterEnable=1, PCEnable=1, muxSelectAddress=0.
- Program 01 34 12 (LDAC 1234h) -> DECODE, ADDR_LO (LSBaddressEnable), ADDR_HI (MSBaddressEnable), then EXEC with muxSelectAddress=1, muxSelectALUtoAC=1, writeEnableAC=1, instrDone=1. Total 5 cycles; zeroEnable never asserted.
- Opcode 09 (SUB) -> EXEC with ALUselectLine=001, writeEnableAC=1, zeroEnable=1, muxSelectZero=0, 3 cycles total. Opcode 0B -> ALUselectLine=011, muxSelectZero=1.
- JMPZ 06 00 80 with zeroFlag=1 -> EXEC PCEnable=1, muxSelectPC=1. With zeroFlag=0 -> EXEC PCEnable=0, instrDone=1, next state FETCH.
- Opcode A5 (illegal) -> FETCH, DECODE with instrDone=1, then FETCH. No write enables asserted.
- reset pulsed during ADDR_HI of STAC -> writeEnableMem never asserted; the FSM is in FETCH on the first cycle after release.
